// File: rtl/axi_ram_slave.sv
// AXI4 memory slave: word-organised RAM with independent read and write burst engines,
// byte strobes, FIXED/INCR/WRAP bursts and SLVERR on illegal commands or out-of-range beats.
module axi_ram_slave #(
    parameter int AXI_ID_WD   = 4,
    parameter int AXI_DATA_WD = 32,
    parameter int AXI_ADDR_WD = 32,
    parameter int AXI_STRB_WD = AXI_DATA_WD / 8,
    parameter int MEM_ADDR_WD = 12,
    parameter int ERR_ON_OOR  = 1
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    input  logic [AXI_ADDR_WD-1:0] S_AXI_AWADDR,
    input  logic [AXI_ID_WD-1:0]   S_AXI_AWID,
    input  logic [1:0]             S_AXI_AWBURST,
    input  logic [2:0]             S_AXI_AWSIZE,
    input  logic [7:0]             S_AXI_AWLEN,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [AXI_DATA_WD-1:0] S_AXI_WDATA,
    input  logic [AXI_STRB_WD-1:0] S_AXI_WSTRB,
    input  logic                   S_AXI_WLAST,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [AXI_ID_WD-1:0]   S_AXI_BID,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [AXI_ADDR_WD-1:0] S_AXI_ARADDR,
    input  logic [AXI_ID_WD-1:0]   S_AXI_ARID,
    input  logic [1:0]             S_AXI_ARBURST,
    input  logic [2:0]             S_AXI_ARSIZE,
    input  logic [7:0]             S_AXI_ARLEN,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [AXI_DATA_WD-1:0] S_AXI_RDATA,
    output logic [AXI_ID_WD-1:0]   S_AXI_RID,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RLAST,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY
);
    localparam int LSB   = $clog2(AXI_STRB_WD);
    localparam int WORDS = 2 ** (MEM_ADDR_WD - LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_WD-1:0] mem [WORDS];

    function automatic logic [AXI_ADDR_WD-1:0] next_addr(input logic [AXI_ADDR_WD-1:0] addr,
                                                         input logic [1:0] burst,
                                                         input logic [2:0] size,
                                                         input logic [7:0] len);
        logic [AXI_ADDR_WD-1:0] incr, aligned, mask;
        incr    = AXI_ADDR_WD'(1) << size;
        aligned = addr & ~(incr - AXI_ADDR_WD'(1));
        mask    = ((AXI_ADDR_WD'(len) + AXI_ADDR_WD'(1)) << size) - AXI_ADDR_WD'(1);
        case (burst)
            2'b01:   next_addr = aligned + incr;
            2'b10:   next_addr = (addr & ~mask) | ((aligned + incr) & mask);
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic bad_cmd(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [7:0] len);
        bad_cmd = (size > 3'(LSB)) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic out_of_range(input logic [AXI_ADDR_WD-1:0] addr);
        out_of_range = (ERR_ON_OOR != 0) && (|addr[AXI_ADDR_WD-1:MEM_ADDR_WD]);
    endfunction

    w_state_t               w_state;
    logic [AXI_ADDR_WD-1:0] w_addr;
    logic [AXI_ID_WD-1:0]   w_id;
    logic [1:0]             w_burst;
    logic [2:0]             w_size;
    logic [7:0]             w_len, w_cnt;
    logic                   w_bad, w_err;
    logic                   aw_fire, w_fire, beat_oor, wlast_err, mem_we, aw_bad;

    always_comb begin
        aw_fire   = S_AXI_AWVALID && S_AXI_AWREADY;
        w_fire    = S_AXI_WVALID && S_AXI_WREADY;
        aw_bad    = bad_cmd(S_AXI_AWBURST, S_AXI_AWSIZE, S_AXI_AWLEN);
        beat_oor  = out_of_range(w_addr);
        wlast_err = S_AXI_WLAST != (w_cnt == 8'd0);
        mem_we    = w_fire && !w_bad && !beat_oor;
    end

    // A WLAST mismatch is only reported; illegal commands and OOR beats are dropped.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < AXI_STRB_WD; i++) begin
                if (S_AXI_WSTRB[i])
                    mem[w_addr[MEM_ADDR_WD-1:LSB]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            w_addr        <= '0;
            w_id          <= '0;
            w_burst       <= '0;
            w_size        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_bad         <= 1'b0;
            w_err         <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_BID     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_addr        <= S_AXI_AWADDR;
                        w_id          <= S_AXI_AWID;
                        w_burst       <= S_AXI_AWBURST;
                        w_size        <= S_AXI_AWSIZE;
                        w_len         <= S_AXI_AWLEN;
                        w_cnt         <= S_AXI_AWLEN;
                        w_bad         <= aw_bad;
                        w_err         <= aw_bad;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_burst, w_size, w_len);
                        w_cnt  <= w_cnt - 8'd1;
                        w_err  <= w_err || beat_oor || wlast_err;
                        if (w_cnt == 8'd0) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BID    <= w_id;
                            S_AXI_BRESP  <= (w_err || beat_oor || wlast_err) ? 2'b10 : 2'b00;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_t               r_state;
    logic [AXI_ADDR_WD-1:0] r_addr;
    logic [1:0]             r_burst;
    logic [2:0]             r_size;
    logic [7:0]             r_len, r_cnt;
    logic                   r_bad, ar_bad, ar_err, r_next_err;

    always_comb begin
        ar_bad     = bad_cmd(S_AXI_ARBURST, S_AXI_ARSIZE, S_AXI_ARLEN);
        ar_err     = ar_bad || out_of_range(S_AXI_ARADDR);
        r_next_err = r_bad || out_of_range(r_addr);
    end

    // r_addr always holds the address of the beat that will be presented next.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            r_addr        <= '0;
            r_burst       <= '0;
            r_size        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_bad         <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_addr        <= next_addr(S_AXI_ARADDR, S_AXI_ARBURST, S_AXI_ARSIZE, S_AXI_ARLEN);
                        r_burst       <= S_AXI_ARBURST;
                        r_size        <= S_AXI_ARSIZE;
                        r_len         <= S_AXI_ARLEN;
                        r_cnt         <= S_AXI_ARLEN;
                        r_bad         <= ar_bad;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RID     <= S_AXI_ARID;
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
                        S_AXI_RRESP   <= ar_err ? 2'b10 : 2'b00;
                        S_AXI_RDATA   <= ar_err ? '0 : mem[S_AXI_ARADDR[MEM_ADDR_WD-1:LSB]];
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_addr      <= next_addr(r_addr, r_burst, r_size, r_len);
                            r_cnt       <= r_cnt - 8'd1;
                            S_AXI_RLAST <= (r_cnt == 8'd1);
                            S_AXI_RRESP <= r_next_err ? 2'b10 : 2'b00;
                            S_AXI_RDATA <= r_next_err ? '0 : mem[r_addr[MEM_ADDR_WD-1:LSB]];
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: scoreboard queues hold expected B and R beats,
// popped and compared as the slave returns responses.
module tb_axi_ram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [3:0]  awid = '0, arid = '0, wstrb = '0, bid, rid;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0;

    always #5 clk = ~clk;

    axi_ram_slave #(
        .AXI_ID_WD(4), .AXI_DATA_WD(32), .AXI_ADDR_WD(32), .AXI_STRB_WD(4),
        .MEM_ADDR_WD(12), .ERR_ON_OOR(1)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWBURST(awburst),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARBURST(arburst),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARLEN(arlen), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RID(rid),
        .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;
    typedef struct packed {logic [1:0] resp; logic [3:0] id;} bbeat_t;
    rbeat_t      rq[$];
    bbeat_t      bq[$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          checks = 0;
    int          errors = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic expect_read(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        rq.push_back('{d, r, l, id});
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                               input logic [2:0] size, input logic [7:0] len, input int last_at,
                               input logic [1:0] exp_resp);
        int n;
        bbeat_t e;
        bq.push_back('{exp_resp, id});
        awaddr = addr; awid = id; awburst = burst; awsize = size; awlen = len; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("aw");
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) timeout_fail("w");
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("b");
        else begin
            e = bq.pop_front();
            check_output("bresp", 32'(bresp), 32'(e.resp));
            check_output("bid", 32'(bid), 32'(e.id));
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                                  input logic [2:0] size, input logic [7:0] len,
                                  input logic [3:0] pat, input int n_collect);
        int n, got, k;
        logic held;
        logic [31:0] hd;
        logic hl;
        rbeat_t e;
        araddr = addr; arid = id; arburst = burst; arsize = size; arlen = len; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("ar");
        @(negedge clk);
        arvalid = 1'b0;
        got = 0; k = 0; n = 0; held = 1'b0; hd = '0; hl = 1'b0;
        while (got < n_collect && n < 200) begin
            rready = pat[k % 4];
            k++;
            if (rvalid) begin
                if (held) begin
                    check_output("rdata_stall", rdata, hd);
                    check_output("rlast_stall", 32'(rlast), 32'(hl));
                end
                if (rready) begin
                    if (rq.size() == 0) timeout_fail("rq_empty");
                    else begin
                        e = rq.pop_front();
                        check_output("rdata", rdata, e.data);
                        check_output("rresp", 32'(rresp), 32'(e.resp));
                        check_output("rlast", 32'(rlast), 32'(e.last));
                        check_output("rid", 32'(rid), 32'(e.id));
                    end
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hd = rdata; hl = rlast;
                end
            end
            @(negedge clk);
            n++;
        end
        if (got < n_collect) timeout_fail("r");
        rready = 1'b0;
        if (n_collect == int'(len) + 1) begin
            check_output("rvalid_after", 32'(rvalid), 32'd0);
            check_output("arready_after", 32'(arready), 32'd1);
        end
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        check_output("rst_awready", 32'(awready), 32'd1);
        check_output("rst_arready", 32'(arready), 32'd1);
        check_output("rst_wready", 32'(wready), 32'd0);
        check_output("rst_bvalid", 32'(bvalid), 32'd0);
        check_output("rst_rvalid", 32'(rvalid), 32'd0);
        check_output("rst_rlast", 32'(rlast), 32'd0);
        check_output("rst_bresp", 32'(bresp), 32'd0);
        check_output("rst_rresp", 32'(rresp), 32'd0);
        check_output("rst_bid", 32'(bid), 32'd0);
        check_output("rst_rid", 32'(rid), 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero words 0x00..0x3C so later partial-strobe results are defined.
        for (int i = 0; i < 16; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
        write_burst(32'h0, 4'd1, 2'b01, 3'd2, 8'd15, 15, 2'b00);

        wd[0] = 32'hA5A5A5A5; ws[0] = 4'b0101;
        write_burst(32'h10, 4'd3, 2'b01, 3'd2, 8'd0, 0, 2'b00);
        expect_read(32'h00A500A5, 2'b00, 1'b1, 4'd5);
        apply_stimulus(32'h10, 4'd5, 2'b01, 3'd2, 8'd0, 4'b1111, 1);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        write_burst(32'h38, 4'd2, 2'b10, 3'd2, 8'd3, 3, 2'b00);
        expect_read(32'd3, 2'b00, 1'b0, 4'd6);
        expect_read(32'd4, 2'b00, 1'b0, 4'd6);
        expect_read(32'd1, 2'b00, 1'b0, 4'd6);
        expect_read(32'd2, 2'b00, 1'b1, 4'd6);
        apply_stimulus(32'h30, 4'd6, 2'b01, 3'd2, 8'd3, 4'b1111, 4);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
        write_burst(32'h20, 4'd4, 2'b01, 3'd2, 8'd3, 3, 2'b00);
        for (int i = 0; i < 4; i++) expect_read(32'hC0DE0000 + 32'(i), 2'b00, 1'b0, 4'd9);
        expect_read(32'd3, 2'b00, 1'b0, 4'd9);
        expect_read(32'd4, 2'b00, 1'b0, 4'd9);
        expect_read(32'd1, 2'b00, 1'b0, 4'd9);
        expect_read(32'd2, 2'b00, 1'b1, 4'd9);
        apply_stimulus(32'h20, 4'd9, 2'b01, 3'd2, 8'd7, 4'b1001, 8);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(32'h0001_0000, 4'd7, 2'b01, 3'd2, 8'd0, 0, 2'b10);
        expect_read(32'h0, 2'b00, 1'b1, 4'd1);
        apply_stimulus(32'h0, 4'd1, 2'b01, 3'd2, 8'd0, 4'b1111, 1);
        expect_read(32'h0, 2'b10, 1'b0, 4'd2);
        expect_read(32'h0, 2'b10, 1'b1, 4'd2);
        apply_stimulus(32'h0001_0000, 4'd2, 2'b01, 3'd2, 8'd1, 4'b1111, 2);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'h10 * 32'(i + 1); ws[i] = 4'hF; end
        write_burst(32'h0, 4'd8, 2'b01, 3'd2, 8'd3, 2, 2'b10);
        for (int i = 0; i < 4; i++) expect_read(32'h10 * 32'(i + 1), 2'b00, (i == 3), 4'd3);
        apply_stimulus(32'h0, 4'd3, 2'b01, 3'd2, 8'd3, 4'b1111, 4);

        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        write_burst(32'h4, 4'd10, 2'b01, 3'd3, 8'd0, 0, 2'b10);
        expect_read(32'h20, 2'b00, 1'b1, 4'd4);
        apply_stimulus(32'h4, 4'd4, 2'b01, 3'd2, 8'd0, 4'b1111, 1);
        expect_read(32'h0, 2'b10, 1'b1, 4'd11);
        apply_stimulus(32'h4, 4'd11, 2'b11, 3'd2, 8'd0, 4'b1111, 1);

        // Abort a read while beat 2 of 4 is on the bus, between clock edges.
        expect_read(32'd3, 2'b00, 1'b0, 4'd12);
        expect_read(32'd4, 2'b00, 1'b0, 4'd12);
        apply_stimulus(32'h30, 4'd12, 2'b01, 3'd2, 8'd3, 4'b1111, 2);
        check_output("mid_rvalid", 32'(rvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("async_rvalid", 32'(rvalid), 32'd0);
        check_output("async_arready", 32'(arready), 32'd1);
        check_output("async_awready", 32'(awready), 32'd1);
        rq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_read(32'd3, 2'b00, 1'b0, 4'd13);
        expect_read(32'd4, 2'b00, 1'b0, 4'd13);
        expect_read(32'd1, 2'b00, 1'b0, 4'd13);
        expect_read(32'd2, 2'b00, 1'b1, 4'd13);
        apply_stimulus(32'h30, 4'd13, 2'b01, 3'd2, 8'd3, 4'b1111, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- Parametrised AXI4 full-protocol memory slave, successor to the basic burst memory model used in DMA benches and SoC-level simulation.
- Word-organised dual-port RAM with independent read and write engines.
- Over the simple model it adds:
  - WSTRB byte enables
  - WRAP bursts
  - narrow transfers
  - protocol and range error responses (SLVERR)
  - WLAST checking
  - a configurable out-of-range policy

Parameters:
- AXI_ID_WD, 4, ID width for AW/AR/B/R.
- AXI_DATA_WD, 32, data width; power of two, 32..256.
- AXI_ADDR_WD, 32, AXI address width.
- AXI_STRB_WD, AXI_DATA_WD/8, strobe width.
- MEM_ADDR_WD, 12, byte-address bits actually backed by RAM (2^MEM_ADDR_WD bytes).
- ERR_ON_OOR, 1, 1 = out-of-range access returns SLVERR; 0 = address aliases modulo RAM size with OKAY.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  asynchronous active-high reset
- S_AXI_AWADDR/AWID/AWBURST/AWSIZE/AWLEN  in  AXI_ADDR_WD/AXI_ID_WD/2/3/8  write address
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1  AW handshake
- S_AXI_WDATA/WSTRB/WLAST  in  AXI_DATA_WD/AXI_STRB_WD/1  write data
- S_AXI_WVALID in 1; S_AXI_WREADY out 1  W handshake
- S_AXI_BID/BRESP  out  AXI_ID_WD/2  write response
- S_AXI_BVALID out 1; S_AXI_BREADY in 1  B handshake
- S_AXI_ARADDR/ARID/ARBURST/ARSIZE/ARLEN  in  as AW  read address
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1  AR handshake
- S_AXI_RDATA/RID/RRESP/RLAST  out  AXI_DATA_WD/AXI_ID_WD/2/1  read data
- S_AXI_RVALID out 1; S_AXI_RREADY in 1  R handshake

Behaviour:

Reset:
- S_AXI_ARESET is the one clock domain's asynchronous, active-high reset.
- Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0.
- Reset mid-burst aborts both engines to IDLE immediately. RAM contents are not reset.

Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
- W_IDLE: AWREADY=1. On AW fire, latch addr/id/burst/size/len, load beat counter = AWLEN, compute the error flag. Go to W_DATA next cycle (WREADY=1, AWREADY=0).
- W_DATA: one beat per W fire. Lanes with WSTRB=1 are written to word index addr[MEM_ADDR_WD-1:log2(AXI_STRB_WD)]. Then address advances and counter decrements.
- End of burst is decided by the counter reaching 0, not by WLAST. On that beat go to W_RESP; BVALID=1 the following cycle.
- W_RESP: BID = latched ID. Hold BVALID/BID/BRESP until B fire, then W_IDLE (AWREADY=1 the next cycle).
- Minimum AW-to-B latency is 3 cycles for a 1-beat burst.

Write error (BRESP=2'b10 SLVERR), any of:
- AWSIZE > log2(AXI_STRB_WD)
- AWBURST=2'b11
- WRAP with AWLEN not in {1,3,7,15}
- any beat address out of range with ERR_ON_OOR=1
- WLAST differs from (counter==0) on any beat

On error, data beats are still accepted but suppressed (no RAM write) for illegal size/burst/OOR beats. WLAST mismatch alone does not suppress writes.

Read FSM (R_IDLE -> R_DATA -> R_IDLE):
- R_IDLE: ARREADY=1. On AR fire, latch fields and go to R_DATA.
- First RVALID comes the cycle after AR fire, with beat-0 data registered. RLAST=1 exactly on beat ARLEN.
- On R fire of a non-last beat, the next beat is presented the next cycle, giving back-to-back throughput of 1 beat/cycle.
- While RVALID && !RREADY, RDATA/RID/RRESP/RLAST are held stable.
- After the last R fire, RVALID=0 and ARREADY=1 the next cycle.
- Error conditions mirror write (size, burst, WRAP len, OOR). Error bursts still return ARLEN+1 beats with RRESP=SLVERR and RDATA=0. Error is evaluated per beat for OOR.
- The read engine observes RAM writes committed on earlier cycles. Same-cycle write/read to the same word returns the old data.

Address arithmetic (shared next-address function, AXI_ADDR_WD wide):
- FIXED: address unchanged.
- INCR: next = (addr aligned down to 2^size) + 2^size. Wraps modulo 2^AXI_ADDR_WD; no 4 KB check.
- WRAP: container = (len+1) << size, base = addr aligned down to container. next = base + ((aligned addr + 2^size) mod container).
- Out of range: any address bit at position >= MEM_ADDR_WD nonzero. With ERR_ON_OOR=0 those bits are ignored.
- Narrow reads return the full word; the master selects lanes.

Test Plan:
- 1-beat INCR write, addr 0x10, data 0xA5A5A5A5, WSTRB 4'b0101; then read of 0x10 -> RDATA 0x00A500A5 (RAM pre-zeroed), RRESP=OKAY, RLAST=1 on first beat, BRESP=OKAY.
- WRAP len=3 size=2 at addr 0x38, data 1,2,3,4 written to 0x38,0x3C,0x30,0x34; INCR read len=3 from 0x30 -> 3,4,1,2.
- INCR read len=7 with RREADY toggled 1,0,0,1,... -> 8 beats, data stable through stalls, RLAST only on beat 8, RID=ARID.
- Write to 0x0001_0000 with ERR_ON_OOR=1 -> BRESP=SLVERR, RAM unchanged. Read there with len=1 -> 2 beats, RRESP=SLVERR, RDATA=0.
- AWLEN=3 with WLAST on beat 2 -> all 4 beats accepted and written, BRESP=SLVERR. AWSIZE=3 on a 32-bit bus -> SLVERR, no write.
- S_AXI_ARESET asserted mid read burst (beat 2 of 4) -> RVALID=0 and ARREADY=1 asynchronously. A new read returns previously written data intact.
